vga_timing_gen: RTL and testbench

Generates 640x480@60 Hz VGA raster timing from `pixel_clk_25`. It drives the pixel coordinates (`vga_x`, `vga_y`) and `vid_active` consumed by the button canvas and its pixel memory read port. It also drives the `hsync`/`vsync` pins, delayed to line up with the registered RGB path, plus frame and line markers for frame-synchronous logic.

---
 rtl/vga_timing_gen.sv | 153 +++++++++++++++
 tb/tb_vga_timing_gen.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 Hz raster timing generator.
// Free-running horizontal/vertical counters drive the pixel coordinates and
// the active-video flag directly. Sync outputs are delayed through a short
// shift register so they line up with the registered RGB path. Line/frame
// markers and a frame counter are registered alongside the counters.
module vga_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int SYNC_DELAY = 1
) (
  input  logic       pixel_clk_25,
  input  logic       reset,
  output logic [9:0] vga_x,
  output logic [9:0] vga_y,
  output logic       vid_active,
  output logic       hsync,
  output logic       vsync,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Counter limits and sync windows as 10-bit constants for direct compares.
  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT_END  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT_END  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST    = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST    = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  // Totals must fit the 10-bit counters, and the sync pipe depth is bounded.
  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_totals
    $error("vga_timing_gen: H_TOTAL/V_TOTAL must not exceed 1024");
  end
  if (SYNC_DELAY < 0 || SYNC_DELAY > 4) begin : g_bad_delay
    $error("vga_timing_gen: SYNC_DELAY must be in 0..4");
  end

  logic [9:0] h_r;
  logic [9:0] v_r;
  logic       line_start_r;
  logic       frame_start_r;
  logic [7:0] frame_count_r;
  logic       end_of_line_s;
  logic       end_of_frame_s;
  logic       hsync_raw_s;
  logic       vsync_raw_s;
  logic       vid_active_s;

  assign end_of_line_s  = (h_r == H_LAST);
  assign end_of_frame_s = end_of_line_s && (v_r == V_LAST);

  // Raster counters: h every cycle, v advances and wraps only when h wraps.
  always_ff @(posedge pixel_clk_25) begin
    if (reset) begin
      h_r <= 10'd0;
      v_r <= 10'd0;
    end else if (end_of_line_s) begin
      h_r <= 10'd0;
      if (v_r == V_LAST) begin
        v_r <= 10'd0;
      end else begin
        v_r <= v_r + 10'd1;
      end
    end else begin
      h_r <= h_r + 10'd1;
    end
  end

  // Undelayed active-low syncs and the active-video window, decoded from the counters.
  always_comb begin
    hsync_raw_s  = 1'b1;
    vsync_raw_s  = 1'b1;
    vid_active_s = 1'b0;
    if (h_r >= HS_FIRST && h_r <= HS_LAST) begin
      hsync_raw_s = 1'b0;
    end else begin
      hsync_raw_s = 1'b1;
    end
    if (v_r >= VS_FIRST && v_r <= VS_LAST) begin
      vsync_raw_s = 1'b0;
    end else begin
      vsync_raw_s = 1'b1;
    end
    if (h_r < H_ACT_END && v_r < V_ACT_END) begin
      vid_active_s = 1'b1;
    end else begin
      vid_active_s = 1'b0;
    end
  end

  // Line/frame markers fire on the wrap edge so they coincide with the new origin.
  always_ff @(posedge pixel_clk_25) begin
    if (reset) begin
      line_start_r  <= 1'b0;
      frame_start_r <= 1'b0;
      frame_count_r <= 8'd0;
    end else begin
      line_start_r  <= end_of_line_s;
      frame_start_r <= end_of_frame_s;
      if (end_of_frame_s) begin
        frame_count_r <= frame_count_r + 8'd1;
      end else begin
        frame_count_r <= frame_count_r;
      end
    end
  end

  if (SYNC_DELAY == 0) begin : g_no_delay
    assign hsync = hsync_raw_s;
    assign vsync = vsync_raw_s;
  end else begin : g_delay
    logic [SYNC_DELAY-1:0] hs_pipe_r;
    logic [SYNC_DELAY-1:0] vs_pipe_r;

    // Sync shift register; reset flushes every stage to the inactive level.
    always_ff @(posedge pixel_clk_25) begin
      if (reset) begin
        hs_pipe_r <= {SYNC_DELAY{1'b1}};
        vs_pipe_r <= {SYNC_DELAY{1'b1}};
      end else begin
        hs_pipe_r[0] <= hsync_raw_s;
        vs_pipe_r[0] <= vsync_raw_s;
        for (int i = 1; i < SYNC_DELAY; i++) begin
          hs_pipe_r[i] <= hs_pipe_r[i-1];
          vs_pipe_r[i] <= vs_pipe_r[i-1];
        end
      end
    end

    assign hsync = hs_pipe_r[SYNC_DELAY-1];
    assign vsync = vs_pipe_r[SYNC_DELAY-1];
  end

  assign vga_x       = h_r;
  assign vga_y       = v_r;
  assign vid_active  = vid_active_s;
  assign line_start  = line_start_r;
  assign frame_start = frame_start_r;
  assign frame_count = frame_count_r;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: one full-size instance plus two shrunken-raster
// instances (sync delay 1 and 0) so whole frames and the 8-bit frame counter
// wrap fit in a short run. Every cycle is compared against an arithmetic
// model driven by the number of clock edges since reset release.
module tb_vga_timing_gen;

  // Shrunken raster: 15 x 10 totals, 150-cycle frames.
  localparam int SHA = 8, SHF = 2, SHS = 3, SHB = 2;
  localparam int SVA = 6, SVF = 1, SVS = 2, SVB = 1;
  localparam int SFT = (SHA + SHF + SHS + SHB) * (SVA + SVF + SVS + SVB);

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_s = 1'b1;

  logic [9:0] a_x, a_y, s_x, s_y, z_x, z_y;
  logic       a_act, a_hs, a_vs, a_ls, a_fs;
  logic       s_act, s_hs, s_vs, s_ls, s_fs;
  logic       z_act, z_hs, z_vs, z_ls, z_fs;
  logic [7:0] a_fc, s_fc, z_fc;

  int n_cmp = 0;
  int n_bad = 0;
  int ta = 0;
  int ts = 0;

  always #5 clk = ~clk;

  vga_timing_gen dut_a (
    .pixel_clk_25(clk), .reset(rst_a),
    .vga_x(a_x), .vga_y(a_y), .vid_active(a_act), .hsync(a_hs), .vsync(a_vs),
    .line_start(a_ls), .frame_start(a_fs), .frame_count(a_fc)
  );

  vga_timing_gen #(
    .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB), .SYNC_DELAY(1)
  ) dut_s (
    .pixel_clk_25(clk), .reset(rst_s),
    .vga_x(s_x), .vga_y(s_y), .vid_active(s_act), .hsync(s_hs), .vsync(s_vs),
    .line_start(s_ls), .frame_start(s_fs), .frame_count(s_fc)
  );

  vga_timing_gen #(
    .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB), .SYNC_DELAY(0)
  ) dut_z (
    .pixel_clk_25(clk), .reset(rst_s),
    .vga_x(z_x), .vga_y(z_y), .vid_active(z_act), .hsync(z_hs), .vsync(z_vs),
    .line_start(z_ls), .frame_start(z_fs), .frame_count(z_fc)
  );

  // Elapsed non-reset clock edges per reset domain: the model's time base.
  always @(posedge clk) begin
    ta <= rst_a ? 0 : ta + 1;
    ts <= rst_s ? 0 : ts + 1;
  end

  task automatic cmp(input string nm, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (ta=%0d ts=%0d)", nm, got, exp, ta, ts);
      if (n_bad >= 100) begin
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
      end
    end
  endtask

  // Sync level at time t: the raw window test applied d cycles earlier, idle before that.
  function automatic int m_sync(input int t, input int d, input int ht, input int vt,
                                input int first, input int width, input bit is_v);
    int tt, pos;
    if (t < d) return 1;
    tt  = t - d;
    pos = is_v ? (tt / ht) % vt : tt % ht;
    return (pos >= first && pos < first + width) ? 0 : 1;
  endfunction

  task automatic check_dut(input string nm, input int t,
                           input int ha, input int hf, input int hsw, input int hb,
                           input int va, input int vf, input int vsw, input int vb, input int d,
                           input logic [9:0] x, input logic [9:0] y, input logic act,
                           input logic hs, input logic vs, input logic ls, input logic fs,
                           input logic [7:0] fc);
    int ht, vt, ft, h, v;
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    ft = ht * vt;
    h  = t % ht;
    v  = (t / ht) % vt;
    cmp({nm, ".vga_x"}, int'(x), h);
    cmp({nm, ".vga_y"}, int'(y), v);
    cmp({nm, ".vid_active"}, int'(act), (h < ha && v < va) ? 1 : 0);
    cmp({nm, ".hsync"}, int'(hs), m_sync(t, d, ht, vt, ha + hf, hsw, 1'b0));
    cmp({nm, ".vsync"}, int'(vs), m_sync(t, d, ht, vt, va + vf, vsw, 1'b1));
    cmp({nm, ".line_start"}, int'(ls), (t > 0 && h == 0) ? 1 : 0);
    cmp({nm, ".frame_start"}, int'(fs), (t > 0 && t % ft == 0) ? 1 : 0);
    cmp({nm, ".frame_count"}, int'(fc), (t / ft) % 256);
  endtask

  task automatic step();
    @(negedge clk);
    check_dut("a", ta, 640, 16, 96, 48, 480, 10, 2, 33, 1,
              a_x, a_y, a_act, a_hs, a_vs, a_ls, a_fs, a_fc);
    check_dut("s", ts, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB, 1,
              s_x, s_y, s_act, s_hs, s_vs, s_ls, s_fs, s_fc);
    check_dut("z", ts, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB, 0,
              z_x, z_y, z_act, z_hs, z_vs, z_ls, z_fs, z_fc);
  endtask

  typedef struct {
    int         t;
    logic [9:0] x;
    logic [9:0] y;
    logic       act;
    logic       hs;
    logic       ls;
    logic [7:0] fc;
  } vec_t;

  vec_t tbl[13];

  initial begin
    int guard;
    int hold_a;
    int hold_s;

    // Hand-derived checkpoints on the full-size raster (sync delay 1).
    tbl[0]  = '{0,    10'd0,   10'd0, 1'b1, 1'b1, 1'b0, 8'd0};
    tbl[1]  = '{1,    10'd1,   10'd0, 1'b1, 1'b1, 1'b0, 8'd0};
    tbl[2]  = '{639,  10'd639, 10'd0, 1'b1, 1'b1, 1'b0, 8'd0};
    tbl[3]  = '{640,  10'd640, 10'd0, 1'b0, 1'b1, 1'b0, 8'd0};
    tbl[4]  = '{656,  10'd656, 10'd0, 1'b0, 1'b1, 1'b0, 8'd0};
    tbl[5]  = '{657,  10'd657, 10'd0, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[6]  = '{752,  10'd752, 10'd0, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[7]  = '{753,  10'd753, 10'd0, 1'b0, 1'b1, 1'b0, 8'd0};
    tbl[8]  = '{799,  10'd799, 10'd0, 1'b0, 1'b1, 1'b0, 8'd0};
    tbl[9]  = '{800,  10'd0,   10'd1, 1'b1, 1'b1, 1'b1, 8'd0};
    tbl[10] = '{801,  10'd1,   10'd1, 1'b1, 1'b1, 1'b0, 8'd0};
    tbl[11] = '{1456, 10'd656, 10'd1, 1'b0, 1'b1, 1'b0, 8'd0};
    tbl[12] = '{1457, 10'd657, 10'd1, 1'b0, 1'b0, 1'b0, 8'd0};

    // Reset held for 5 cycles: origin, idle syncs, counter cleared.
    repeat (2) @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      step();
      cmp("rst.a_x", int'(a_x), 0);
      cmp("rst.a_y", int'(a_y), 0);
      cmp("rst.a_hsync", int'(a_hs), 1);
      cmp("rst.a_vsync", int'(a_vs), 1);
      cmp("rst.a_frame_count", int'(a_fc), 0);
    end
    rst_a = 1'b0;
    rst_s = 1'b0;

    // Table-driven checkpoints along the first two full-size lines.
    for (int i = 0; i < 13; i++) begin
      guard = 0;
      while (ta < tbl[i].t && guard < 2000) begin
        step();
        guard++;
      end
      cmp("tbl.reached", ta, tbl[i].t);
      cmp("tbl.vga_x", int'(a_x), int'(tbl[i].x));
      cmp("tbl.vga_y", int'(a_y), int'(tbl[i].y));
      cmp("tbl.vid_active", int'(a_act), int'(tbl[i].act));
      cmp("tbl.hsync", int'(a_hs), int'(tbl[i].hs));
      cmp("tbl.line_start", int'(a_ls), int'(tbl[i].ls));
      cmp("tbl.frame_count", int'(a_fc), int'(tbl[i].fc));
    end

    // Mid-frame reset while both syncs are low on the shrunken raster (h=11, v=7).
    guard = 0;
    while (ts % SFT != 7 * 15 + 11 && guard < 400) begin
      step();
      guard++;
    end
    cmp("midrst.position_found", ts % SFT, 7 * 15 + 11);
    cmp("midrst.pre_hsync", int'(s_hs), 0);
    cmp("midrst.pre_vsync", int'(s_vs), 0);
    cmp("midrst.pre_hsync_d0", int'(z_hs), 0);
    cmp("midrst.pre_vsync_d0", int'(z_vs), 0);
    rst_s = 1'b1;
    step();
    cmp("midrst.vga_x", int'(s_x), 0);
    cmp("midrst.vga_y", int'(s_y), 0);
    cmp("midrst.hsync", int'(s_hs), 1);
    cmp("midrst.vsync", int'(s_vs), 1);
    cmp("midrst.frame_count", int'(s_fc), 0);
    cmp("midrst.line_start", int'(s_ls), 0);
    rst_s = 1'b0;

    // Random reset pulses of 1..3 cycles on both domains.
    hold_a = 0;
    hold_s = 0;
    for (int c = 0; c < 3000; c++) begin
      step();
      if (rst_s) begin
        hold_s--;
        if (hold_s <= 0) rst_s = 1'b0;
      end else if ($urandom_range(0, 299) == 0) begin
        rst_s  = 1'b1;
        hold_s = int'($urandom_range(1, 3));
      end
      if (rst_a) begin
        hold_a--;
        if (hold_a <= 0) rst_a = 1'b0;
      end else if ($urandom_range(0, 699) == 0) begin
        rst_a  = 1'b1;
        hold_a = int'($urandom_range(1, 3));
      end
    end
    rst_a = 1'b0;

    // 256 shrunken frames from a clean reset: frame counter walks through its wrap.
    rst_s = 1'b1;
    step();
    step();
    rst_s = 1'b0;
    guard = 0;
    while (ts < 256 * SFT + 1 && guard < 256 * SFT + 10) begin
      step();
      guard++;
      if (ts == SFT) begin
        cmp("wrap.first_frame_start", int'(s_fs), 1);
        cmp("wrap.first_count", int'(s_fc), 1);
      end else if (ts == SFT - 1) begin
        cmp("wrap.pre_first_frame_start", int'(s_fs), 0);
        cmp("wrap.pre_first_count", int'(s_fc), 0);
      end else if (ts == 255 * SFT) begin
        cmp("wrap.count_255", int'(s_fc), 255);
        cmp("wrap.frame_start_255", int'(s_fs), 1);
      end else if (ts == 256 * SFT - 1) begin
        cmp("wrap.last_before_wrap", int'(s_fc), 255);
        cmp("wrap.last_y", int'(s_y), 9);
        cmp("wrap.last_x", int'(s_x), 14);
      end else if (ts == 256 * SFT) begin
        cmp("wrap.count_0", int'(s_fc), 0);
        cmp("wrap.frame_start_256", int'(s_fs), 1);
        cmp("wrap.line_start_256", int'(s_ls), 1);
        cmp("wrap.origin_x", int'(s_x), 0);
        cmp("wrap.origin_y", int'(s_y), 0);
      end
    end
    cmp("wrap.reached", ts, 256 * SFT + 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
